// File: rtl/data_checker_pkg.sv
// Shared types and constants for the data_checker AXI-Stream sink.
// Optional feature macro used by the top level: DATA_CHECKER_FIRST_ERR_EN.
package data_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W = 512;
  localparam int WORD_W = 64;

  // 64-bit word positions inside a 512-bit beat
  localparam int W_CNT  = 0;
  localparam int W_PKT  = 1;
  localparam int W_NPKT = 6;
  localparam int W_NCNT = 7;

  // err_flags / mismatch vector bit positions
  localparam int ERR_CNT     = 0;
  localparam int ERR_NCNT    = 1;
  localparam int ERR_PKT     = 2;
  localparam int ERR_NPKT    = 3;
  localparam int ERR_TLAST   = 4;
  localparam int ERR_FLAGS_W = 5;

  // Extract one 64-bit word from a beat
  function automatic logic [WORD_W-1:0] get_word(input logic [DATA_W-1:0] d, input int idx);
    return d[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/data_checker_beat_compare.sv
// Purely combinational comparison of one received beat against the locally
// regenerated beat index and packet number.
module data_checker_beat_compare
  import data_checker_pkg::*;
#(
  parameter int BEATS_LOG2 = 2
) (
  input  logic [DATA_W-1:0]      i_tdata,
  input  logic                   i_tlast,
  input  logic [WORD_W-1:0]      i_exp_cnt,
  input  logic [WORD_W-1:0]      i_exp_pkt,
  output logic [ERR_FLAGS_W-1:0] o_mismatch
);

  logic w_exp_last;
  logic w_unused;

  // TLAST belongs on the beat whose low index bits are all ones
  assign w_exp_last = &i_exp_cnt[BEATS_LOG2-1:0];

  // Words 2..5 carry filler and are deliberately ignored
  assign w_unused = ^i_tdata[W_NPKT*WORD_W-1:(W_PKT+1)*WORD_W];

  // Build the per-field mismatch vector
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    o_mismatch            = '0;
    o_mismatch[ERR_CNT]   = get_word(i_tdata, W_CNT)  != i_exp_cnt;
    o_mismatch[ERR_NCNT]  = get_word(i_tdata, W_NCNT) != ~i_exp_cnt;
    o_mismatch[ERR_PKT]   = get_word(i_tdata, W_PKT)  != i_exp_pkt;
    o_mismatch[ERR_NPKT]  = get_word(i_tdata, W_NPKT) != ~i_exp_pkt;
    o_mismatch[ERR_TLAST] = i_tlast != w_exp_last;
  end

endmodule

// File: rtl/data_checker.sv
// data_checker: AXI-Stream sink that checks fixed-length test-pattern packets.
// Optional build macro DATA_CHECKER_FIRST_ERR_EN adds first-error capture ports.
module data_checker
  import data_checker_pkg::*;
#(
  parameter int BEATS_LOG2 = 2,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [63:0]            packet_count,
  input  logic [DATA_W-1:0]      AXIS_RX_TDATA,
  input  logic                   AXIS_RX_TVALID,
  input  logic                   AXIS_RX_TLAST,
  output logic                   AXIS_RX_TREADY,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            packets_rcvd,
  output logic [63:0]            beats_rcvd,
  output logic [ERR_CNT_W-1:0]   error_count,
  output logic [ERR_FLAGS_W-1:0] err_flags
`ifdef DATA_CHECKER_FIRST_ERR_EN
  ,
  output logic                   first_err_valid,
  output logic [63:0]            first_err_beat,
  output logic [63:0]            first_err_exp,
  output logic [63:0]            first_err_act
`endif
);

  state_t                 r_state;
  logic [63:0]            r_target;
  logic [63:0]            r_packets_rcvd;
  logic [63:0]            r_beats_rcvd;
  logic [ERR_CNT_W-1:0]   r_error_count;
  logic [ERR_FLAGS_W-1:0] r_err_flags;
  logic [WORD_W-1:0]      r_exp_cnt;
  logic [WORD_W-1:0]      r_exp_pkt;

  logic                   w_accept;
  logic                   w_check;
  logic                   w_exp_last;
  logic                   w_final;
  logic [63:0]            w_pkts_next;
  logic [ERR_FLAGS_W-1:0] w_mismatch;
  logic                   w_any_err;

  // TREADY decodes the state register only, never TVALID
  assign AXIS_RX_TREADY = (r_state == RUN);
  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign packets_rcvd   = r_packets_rcvd;
  assign beats_rcvd     = r_beats_rcvd;
  assign error_count    = r_error_count;
  assign err_flags      = r_err_flags;

  assign w_accept    = AXIS_RX_TVALID & AXIS_RX_TREADY;
  // A beat accepted in the same cycle as start is dropped unchecked
  assign w_check     = w_accept & ~start;
  assign w_exp_last  = &r_exp_cnt[BEATS_LOG2-1:0];
  assign w_pkts_next = r_packets_rcvd + 64'd1;
  assign w_final     = w_check & AXIS_RX_TLAST & (w_pkts_next == r_target);
  assign w_any_err   = |w_mismatch;

  data_checker_beat_compare #(
    .BEATS_LOG2 (BEATS_LOG2)
  ) u_beat_compare (
    .i_tdata    (AXIS_RX_TDATA),
    .i_tlast    (AXIS_RX_TLAST),
    .i_exp_cnt  (r_exp_cnt),
    .i_exp_pkt  (r_exp_pkt),
    .o_mismatch (w_mismatch)
  );

  // FSM, expected-value generators and status counters
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch, not in the sensitivity list.
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state        <= IDLE;
      r_target       <= '0;
      r_packets_rcvd <= '0;
      r_beats_rcvd   <= '0;
      r_error_count  <= '0;
      r_err_flags    <= '0;
      r_exp_cnt      <= '0;
      r_exp_pkt      <= '0;
    end else if (start) begin
      r_state        <= (packet_count == 64'd0) ? DONE : RUN;
      r_target       <= packet_count;
      r_packets_rcvd <= '0;
      r_beats_rcvd   <= '0;
      r_error_count  <= '0;
      r_err_flags    <= '0;
      r_exp_cnt      <= '0;
      r_exp_pkt      <= '0;
    end else begin
      if (r_state == RUN && w_final) begin
        r_state <= DONE;
      end
      if (w_check) begin
        r_beats_rcvd <= r_beats_rcvd + 64'd1;
        r_exp_cnt    <= r_exp_cnt + 64'd1;
        // Packet number follows the expected TLAST slot, not the received one
        if (w_exp_last) begin
          r_exp_pkt <= r_exp_pkt + 64'd1;
        end
        if (AXIS_RX_TLAST) begin
          r_packets_rcvd <= w_pkts_next;
        end
        if (w_any_err) begin
          r_err_flags <= r_err_flags | w_mismatch;
          if (r_error_count != {ERR_CNT_W{1'b1}}) begin
            r_error_count <= r_error_count + 1'b1;
          end
        end
      end
    end
  end

`ifdef DATA_CHECKER_FIRST_ERR_EN
  logic w_pkt_only;

  // Report pkt_num values only when both counter fields matched
  assign w_pkt_only = ~(|w_mismatch[ERR_NCNT:ERR_CNT]) & (|w_mismatch[ERR_NPKT:ERR_PKT]);

  // Capture details of the first mismatching beat after start
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      first_err_valid <= 1'b0;
      first_err_beat  <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else if (w_check && w_any_err && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_beat  <= r_beats_rcvd;
      first_err_exp   <= w_pkt_only ? r_exp_pkt : r_exp_cnt;
      first_err_act   <= w_pkt_only ? get_word(AXIS_RX_TDATA, W_PKT)
                                    : get_word(AXIS_RX_TDATA, W_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_data_checker.sv
// Directed testbench for data_checker; define DATA_CHECKER_FIRST_ERR_EN to
// also exercise the first-error capture ports.
module tb_data_checker;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [63:0]  packet_count;
  logic [511:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic         busy;
  logic         done;
  logic [63:0]  packets_rcvd;
  logic [63:0]  beats_rcvd;
  logic [31:0]  error_count;
  logic [4:0]   err_flags;
`ifdef DATA_CHECKER_FIRST_ERR_EN
  logic         first_err_valid;
  logic [63:0]  first_err_beat;
  logic [63:0]  first_err_exp;
  logic [63:0]  first_err_act;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_checker dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .packet_count   (packet_count),
    .AXIS_RX_TDATA  (tdata),
    .AXIS_RX_TVALID (tvalid),
    .AXIS_RX_TLAST  (tlast),
    .AXIS_RX_TREADY (tready),
    .busy           (busy),
    .done           (done),
    .packets_rcvd   (packets_rcvd),
    .beats_rcvd     (beats_rcvd),
    .error_count    (error_count),
    .err_flags      (err_flags)
`ifdef DATA_CHECKER_FIRST_ERR_EN
    ,
    .first_err_valid(first_err_valid),
    .first_err_beat (first_err_beat),
    .first_err_exp  (first_err_exp),
    .first_err_act  (first_err_act)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Well-formed beat: counter, pkt_num, their inverses, filler in words 2..5
  function automatic logic [511:0] mk_beat(input logic [63:0] c, input logic [63:0] p);
    logic [511:0] d;
    d = '0;
    d[0*64 +: 64] = c;
    d[1*64 +: 64] = p;
    for (int w = 2; w < 6; w++) d[w*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(w);
    d[6*64 +: 64] = ~p;
    d[7*64 +: 64] = ~c;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] cnt);
    start        = 1'b1;
    packet_count = cnt;
    tick();
    start        = 1'b0;
  endtask

  // Present one beat and wait (bounded) until it is accepted
  task automatic send_beat(input logic [511:0] d, input logic last, input bit chk_done_pre);
    int n;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    n      = 0;
    while (!tready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("tready_wait", {63'd0, tready}, 64'd1);
    if (chk_done_pre) check("done_before_last", {63'd0, done}, 64'd0);
    tick();
  endtask

  // Send clean beats [first, first+n) with TLAST on every 4th beat
  task automatic send_clean(input int first, input int n);
    for (int b = first; b < first + n; b++)
      send_beat(mk_beat(64'(b), 64'(b / 4)), (b % 4) == 3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; packet_count = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_tready",  {63'd0, tready}, 64'd0);
    check("rst_busy",    {63'd0, busy},   64'd0);
    check("rst_done",    {63'd0, done},   64'd0);
    check("rst_beats",   beats_rcvd,      64'd0);
    check("rst_pkts",    packets_rcvd,    64'd0);
    check("rst_errs",    64'(error_count), 64'd0);
    check("rst_flags",   64'(err_flags),  64'd0);
    resetn = 1'b1;
    tick();

    // 1: clean 3-packet stream, TVALID continuous
    do_start(64'd3);
    check("s1_busy", {63'd0, busy}, 64'd1);
    send_clean(0, 12);
    check("s1_beats", beats_rcvd,       64'd12);
    check("s1_pkts",  packets_rcvd,     64'd3);
    check("s1_errs",  64'(error_count), 64'd0);
    check("s1_done",  {63'd0, done},    64'd1);
    check("s1_tready",{63'd0, tready},  64'd0);
    repeat (2) tick();
    check("s1_no_count_in_done", beats_rcvd, 64'd12);
    tvalid = 1'b0;

    // 2: corrupted counter on beat 5 (inverse follows the corrupt value)
    do_start(64'd3);
    check("s2_cleared_done", {63'd0, done}, 64'd0);
    send_clean(0, 5);
    begin
      logic [511:0] d;
      d = mk_beat(64'd5, 64'd1);
      d[0*64 +: 64] = 64'h99;
      d[7*64 +: 64] = ~64'h99;
      send_beat(d, 1'b0, 1'b0);
    end
    check("s2_errs",  64'(error_count), 64'd1);
    check("s2_flags", 64'(err_flags),   64'h03);
`ifdef DATA_CHECKER_FIRST_ERR_EN
    check("s2_fe_valid", {63'd0, first_err_valid}, 64'd1);
    check("s2_fe_beat",  first_err_beat, 64'd5);
    check("s2_fe_exp",   first_err_exp,  64'd5);
    check("s2_fe_act",   first_err_act,  64'h99);
`endif
    send_clean(6, 4);
    check("s2_errs_after", 64'(error_count), 64'd1);
    check("s2_pkts",       packets_rcvd,     64'd3 - 64'd1);
    check("s2_busy",       {63'd0, busy},    64'd1);
    send_clean(8, 2);

    // 6: start mid-packet with a garbage beat presented in the start cycle
    tdata  = '1;
    tlast  = 1'b1;
    tvalid = 1'b1;
    do_start(64'd2);
    tvalid = 1'b0;
    check("s6_beats", beats_rcvd,       64'd0);
    check("s6_pkts",  packets_rcvd,     64'd0);
    check("s6_errs",  64'(error_count), 64'd0);
    check("s6_flags", 64'(err_flags),   64'd0);
    check("s6_busy",  {63'd0, busy},    64'd1);
`ifdef DATA_CHECKER_FIRST_ERR_EN
    check("s6_fe_valid", {63'd0, first_err_valid}, 64'd0);
    check("s6_fe_beat",  first_err_beat, 64'd0);
`endif
    send_clean(0, 8);
    check("s6_errs_after", 64'(error_count), 64'd0);
    check("s6_pkts_after", packets_rcvd,     64'd2);
    check("s6_done",       {63'd0, done},    64'd1);
    tvalid = 1'b0;

    // 3: TLAST missing on beat index 3
    do_start(64'd2);
    send_clean(0, 3);
    send_beat(mk_beat(64'd3, 64'd0), 1'b0, 1'b0);
    check("s3_flags", 64'(err_flags),   64'h10);
    check("s3_errs",  64'(error_count), 64'd1);
    check("s3_pkts",  packets_rcvd,     64'd0);
    send_clean(4, 4);
    check("s3_errs_after", 64'(error_count), 64'd1);
    check("s3_pkts_after", packets_rcvd,     64'd1);
    check("s3_not_done",   {63'd0, done},    64'd0);
    tvalid = 1'b0;

    // Reset overrides a simultaneous start
    resetn = 1'b0;
    start  = 1'b1;
    packet_count = 64'd5;
    tick();
    check("rst2_busy",  {63'd0, busy}, 64'd0);
    check("rst2_beats", beats_rcvd,    64'd0);
    check("rst2_flags", 64'(err_flags), 64'd0);
    resetn = 1'b1;
    start  = 1'b0;
    tick();

    // 4: 40 packets with random TVALID gaps
    do_start(64'd40);
    for (int b = 0; b < 160; b++) begin
      int g;
      g = $urandom_range(5, 0);
      tvalid = 1'b0;
      repeat (g) tick();
      send_beat(mk_beat(64'(b), 64'(b / 4)), (b % 4) == 3, b == 159);
    end
    tvalid = 1'b0;
    check("s4_done",  {63'd0, done},    64'd1);
    check("s4_errs",  64'(error_count), 64'd0);
    check("s4_beats", beats_rcvd,       64'd160);
    check("s4_pkts",  packets_rcvd,     64'd40);

    // 5: zero-length request
    do_start(64'd0);
    check("s5_done", {63'd0, done}, 64'd1);
    check("s5_busy", {63'd0, busy}, 64'd0);
    tdata  = mk_beat(64'd0, 64'd0);
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s5_tready", {63'd0, tready}, 64'd0);
      tick();
    end
    tvalid = 1'b0;
    check("s5_beats", beats_rcvd, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
